// File: rtl/speed_control_pkg.sv
// Shared definitions for the speed select path: code width, saturation limits
// and the sizing helper for the debounce / auto-repeat counters.
package speed_control_pkg;

    localparam int SPEED_W = 2;
    localparam logic [SPEED_W-1:0] SPEED_MIN  = 2'b00;
    localparam logic [SPEED_W-1:0] SPEED_MAX  = 2'b11;
    localparam logic [SPEED_W-1:0] SPEED_STEP = 2'b01;

    // Keys are active-low, so the released level is 1.
    localparam logic KEY_RELEASED = 1'b1;
    localparam logic KEY_PRESSED  = 1'b0;

    // Bits needed for a counter that runs 0..n-1 (at least one bit).
    function automatic int cnt_width(input int n);
        if (n < 2) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/speed_control_key_debounce.sv
// One push button: two-flop synchronizer, debounce counter and press-event
// generation with optional auto-repeat while the key stays debounced-pressed.
module key_debounce
    import speed_control_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500,
    parameter int REPEAT_CYCLES   = 2000
) (
    input  logic Clock,
    input  logic Reset,
    input  logic key_n,
    output logic press
);

    localparam int DCW = cnt_width(DEBOUNCE_CYCLES);
    localparam int RCW = cnt_width(REPEAT_CYCLES);
    localparam logic [DCW-1:0] DEB_LAST = DCW'(DEBOUNCE_CYCLES - 1);
    localparam logic [DCW-1:0] DEB_ONE  = DCW'(1);
    localparam logic [RCW-1:0] RPT_LAST = RCW'((REPEAT_CYCLES > 0) ? (REPEAT_CYCLES - 1) : 0);
    localparam logic [RCW-1:0] RPT_ONE  = RCW'(1);

    logic           sync1_r;
    logic           sync2_r;
    logic           deb_r;
    logic           deb_prev_r;
    logic [DCW-1:0] deb_cnt_r;
    logic [RCW-1:0] rpt_cnt_r;
    logic           press_r;

    logic           mismatch_s;
    logic           flip_s;
    logic           rise_s;
    logic           repeat_s;

    // Debounce decisions; rise_s marks the first cycle after the level went pressed.
    always_comb begin
        mismatch_s = (sync2_r != deb_r);
        flip_s     = mismatch_s && (deb_cnt_r == DEB_LAST);
        rise_s     = (deb_r == KEY_PRESSED) && (deb_prev_r == KEY_RELEASED);
        if ((REPEAT_CYCLES > 0) && (deb_r == KEY_PRESSED) && !rise_s && (rpt_cnt_r == RPT_LAST)) begin
            repeat_s = 1'b1;
        end else begin
            repeat_s = 1'b0;
        end
    end

    // Synchronizer, debounced level and debounce counter.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            sync1_r    <= KEY_RELEASED;
            sync2_r    <= KEY_RELEASED;
            deb_r      <= KEY_RELEASED;
            deb_prev_r <= KEY_RELEASED;
            deb_cnt_r  <= '0;
        end else begin
            sync1_r    <= key_n;
            sync2_r    <= sync1_r;
            deb_prev_r <= deb_r;
            if (flip_s) begin
                deb_r     <= sync2_r;
                deb_cnt_r <= '0;
            end else if (mismatch_s) begin
                deb_cnt_r <= deb_cnt_r + DEB_ONE;
            end else begin
                deb_cnt_r <= '0;
            end
        end
    end

    // Auto-repeat timer, restarted by every event and held at 0 while released.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            rpt_cnt_r <= '0;
            press_r   <= 1'b0;
        end else begin
            press_r <= rise_s || repeat_s;
            if ((deb_r == KEY_RELEASED) || rise_s || (rpt_cnt_r == RPT_LAST)) begin
                rpt_cnt_r <= '0;
            end else begin
                rpt_cnt_r <= rpt_cnt_r + RPT_ONE;
            end
        end
    end

    assign press = press_r;

endmodule

// File: rtl/speed_control.sv
// Two-button speed selector: saturating Speed register stepped by debounced
// up/down press events, with a one-cycle Changed pulse on every real change.
module speed_control
    import speed_control_pkg::*;
#(
    parameter int                 DEBOUNCE_CYCLES = 500,
    parameter int                 REPEAT_CYCLES   = 2000,
    parameter logic [SPEED_W-1:0] RESET_SPEED     = 2'b00
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               KeyUp_n,
    input  logic               KeyDown_n,
    output logic [SPEED_W-1:0] Speed,
    output logic               Changed
);

    logic               up_evt_s;
    logic               down_evt_s;
    logic [SPEED_W-1:0] speed_next_s;
    logic [SPEED_W-1:0] speed_r;
    logic               changed_r;

    key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_CYCLES   (REPEAT_CYCLES)
    ) u_key_up (
        .Clock (Clock),
        .Reset (Reset),
        .key_n (KeyUp_n),
        .press (up_evt_s)
    );

    key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_CYCLES   (REPEAT_CYCLES)
    ) u_key_down (
        .Clock (Clock),
        .Reset (Reset),
        .key_n (KeyDown_n),
        .press (down_evt_s)
    );

    // Next speed: simultaneous events cancel, saturated requests are ignored.
    always_comb begin
        speed_next_s = speed_r;
        if (up_evt_s && !down_evt_s && (speed_r != SPEED_MAX)) begin
            speed_next_s = speed_r + SPEED_STEP;
        end else if (down_evt_s && !up_evt_s && (speed_r != SPEED_MIN)) begin
            speed_next_s = speed_r - SPEED_STEP;
        end else begin
            speed_next_s = speed_r;
        end
    end

    // Speed register and its change strobe.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            speed_r   <= RESET_SPEED;
            changed_r <= 1'b0;
        end else begin
            speed_r   <= speed_next_s;
            changed_r <= (speed_next_s != speed_r);
        end
    end

    assign Speed   = speed_r;
    assign Changed = changed_r;

endmodule

// File: tb/tb_speed_control.sv
// Directed bench for speed_control: a table of held-key phases with expected
// final Speed and Changed pulse counts, plus exact-latency sequences.
module tb_speed_control;

    localparam int DEB = 4;
    localparam int RPT = 8;

    logic       Clock    = 1'b0;
    logic       Reset    = 1'b1;
    logic       key_up_n = 1'b1;
    logic       key_dn_n = 1'b1;
    logic [1:0] speed;
    logic       changed;
    logic [1:0] speed_nr;
    logic       changed_nr;

    int n_checks = 0;
    int n_pass   = 0;
    int chg_cnt  = 0;
    int chg_nr   = 0;

    typedef struct {
        logic rst;
        logic up_n;
        logic dn_n;
        int   cycles;
        int   exp_speed;
        int   exp_chg;
    } vec_t;

    vec_t vecs[$];

    always #5 Clock = ~Clock;

    speed_control #(
        .DEBOUNCE_CYCLES (DEB),
        .REPEAT_CYCLES   (RPT),
        .RESET_SPEED     (2'b00)
    ) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .KeyUp_n   (key_up_n),
        .KeyDown_n (key_dn_n),
        .Speed     (speed),
        .Changed   (changed)
    );

    speed_control #(
        .DEBOUNCE_CYCLES (DEB),
        .REPEAT_CYCLES   (0),
        .RESET_SPEED     (2'b00)
    ) dut_norpt (
        .Clock     (Clock),
        .Reset     (Reset),
        .KeyUp_n   (key_up_n),
        .KeyDown_n (key_dn_n),
        .Speed     (speed_nr),
        .Changed   (changed_nr)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Advance n edges, sampling 1ns after each edge and counting Changed pulses.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge Clock);
            #1;
            chg_cnt += int'(changed);
            chg_nr  += int'(changed_nr);
        end
    endtask

    task automatic do_reset();
        key_up_n = 1'b1;
        key_dn_n = 1'b1;
        Reset    = 1'b1;
        step(2);
        Reset    = 1'b0;
        step(2);
        chg_cnt  = 0;
        chg_nr   = 0;
    endtask

    initial begin
        // {rst, up_n, dn_n, cycles, speed at end, Changed pulses during phase}
        vecs.push_back('{1'b1, 1'b1, 1'b1, 3, 0, 0});
        for (int g = 0; g < 5; g++) begin
            vecs.push_back('{1'b0, 1'b0, 1'b1, 3, 0, 0});
            vecs.push_back('{1'b0, 1'b1, 1'b1, 3, 0, 0});
        end
        vecs.push_back('{1'b0, 1'b1, 1'b1, 10, 0, 0});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 40, 0, 0});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 10, 0, 0});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 16, 2, 2});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 10, 2, 0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 20, 2, 0});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 14, 3, 1});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 10, 3, 0});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 8, 2, 1});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 10, 2, 0});

        step(2);
        foreach (vecs[i]) begin
            Reset    = vecs[i].rst;
            key_up_n = vecs[i].up_n;
            key_dn_n = vecs[i].dn_n;
            chg_cnt  = 0;
            step(vecs[i].cycles);
            check($sformatf("row%0d speed", i), int'(speed), vecs[i].exp_speed);
            check($sformatf("row%0d changed_count", i), chg_cnt, vecs[i].exp_chg);
        end

        // Exact latency of first press and auto-repeat steps up to saturation.
        do_reset();
        check("reset speed", int'(speed), 0);
        check("reset changed", int'(changed), 0);
        key_up_n = 1'b0;
        step(7);
        check("lat pre speed", int'(speed), 0);
        check("lat pre changed_count", chg_cnt, 0);
        step(1);
        check("lat speed1", int'(speed), 1);
        check("lat changed1", int'(changed), 1);
        step(1);
        check("lat changed1 drop", int'(changed), 0);
        chg_cnt = 0;
        step(6);
        check("rpt pre speed", int'(speed), 1);
        check("rpt pre changed_count", chg_cnt, 0);
        step(1);
        check("rpt speed2", int'(speed), 2);
        check("rpt changed2", int'(changed), 1);
        chg_cnt = 0;
        step(8);
        check("rpt speed3", int'(speed), 3);
        check("rpt changed3_count", chg_cnt, 1);
        chg_cnt = 0;
        step(8);
        check("sat speed", int'(speed), 3);
        check("sat changed_count", chg_cnt, 0);
        key_up_n = 1'b1;
        step(10);

        // Reset in the middle of debounce, key kept held through it.
        do_reset();
        key_up_n = 1'b0;
        step(4);
        Reset = 1'b1;
        step(1);
        check("midrst speed", int'(speed), 0);
        check("midrst changed", int'(changed), 0);
        Reset   = 1'b0;
        chg_cnt = 0;
        step(7);
        check("midrst pre speed", int'(speed), 0);
        check("midrst pre changed_count", chg_cnt, 0);
        step(1);
        check("midrst speed1", int'(speed), 1);
        check("midrst changed1", int'(changed), 1);
        key_up_n = 1'b1;
        chg_cnt  = 0;
        step(10);
        check("midrst after speed", int'(speed), 1);
        check("midrst after changed_count", chg_cnt, 0);

        // Auto-repeat disabled: a long hold gives a single step.
        do_reset();
        key_up_n = 1'b0;
        step(100);
        check("norpt speed", int'(speed_nr), 1);
        check("norpt changed_count", chg_nr, 1);
        check("rpt long-hold speed", int'(speed), 3);
        key_up_n = 1'b1;
        step(10);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/speed_control.md
SPEED_CONTROL -- requirements
Module: speed_control

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500: consecutive stable synchronized samples required to accept a key level change; legal range 2..65535.
REQ-002 Parameter REPEAT_CYCLES, default 2000: held-key auto-repeat period in cycles; 0 disables auto-repeat.
REQ-003 Parameter RESET_SPEED, default 2'b00: Speed value loaded by reset.
REQ-004 Clock  input  1  rising-edge clock for all state.
REQ-005 Reset  input  1  synchronous, active-high.
REQ-006 KeyUp_n  input  1  raw push button, active-low, asynchronous to Clock; request for a higher Speed code.
REQ-007 KeyDown_n  input  1  raw push button, active-low, asynchronous to Clock; request for a lower Speed code.
REQ-008 Speed  output  2  registered speed select code, consumed directly by the rate divider's Speed input.
REQ-009 Changed  output  1  registered one-cycle pulse, asserted in the cycle after any edge that modified Speed.

Function
REQ-010 Each key SHALL pass through a two-flop synchronizer before any other logic uses it.
REQ-011 Each key SHALL have a debounced level (pressed/released) and a counter; the counter SHALL increment while the synchronized level differs from the debounced level and SHALL clear to 0 on any cycle where they match.
REQ-012 The debounced level SHALL flip, and the counter SHALL clear, on the edge where the counter equals DEBOUNCE_CYCLES-1 and the mismatch persists; glitches shorter than DEBOUNCE_CYCLES cycles SHALL have no effect.
REQ-013 A press event SHALL be a one-cycle pulse on the edge following the debounced released->pressed transition; release SHALL generate no event.
REQ-014 With REPEAT_CYCLES>0, a key debounced-pressed continuously SHALL generate an additional press event every REPEAT_CYCLES cycles after its initial event, until debounced release.
REQ-015 Up event alone: Speed <= Speed+1, saturating at 2'b11; down event alone: Speed <= Speed-1, saturating at 2'b00.
REQ-016 Up and down events in the same cycle SHALL leave Speed unchanged.
REQ-017 A saturated request (up at 3, down at 0) SHALL leave Speed unchanged and SHALL NOT pulse Changed.
REQ-018 Latency: raw key held stable from edge k SHALL update Speed at edge k+DEBOUNCE_CYCLES+4 (2 sync, debounce, event register, Speed register); Changed SHALL be high for exactly the cycle following that update.
REQ-019 Both keys held simultaneously: each key's events SHALL be processed independently per REQ-015/016.
REQ-020 Speed SHALL never take a value other than its registered value; no combinational path from keys to Speed or Changed.

Reset
REQ-021 On Reset: Speed=RESET_SPEED, Changed=0, synchronizer flops=released (1), debounced levels=released, debounce and repeat counters=0.
REQ-022 Reset asserted mid-debounce or mid-repeat SHALL abort it with no event generated.
REQ-023 A key held through reset deassertion SHALL be treated as a new press and produce one event after the REQ-018 latency.

Structure
REQ-024 Shared package SHALL hold SPEED_W=2, SPEED_MIN=2'b00, SPEED_MAX=2'b11 and the debounce/repeat counter width function; the rate divider uses the same SPEED_W.
REQ-025 Sub-module key_debounce (synchronizer, debounce counter, event and auto-repeat generation) SHALL be instantiated once per key; speed_control holds only the saturating Speed register and Changed logic.

Verification (bench: DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8, RESET_SPEED=0)
REQ-026 Reset, KeyUp_n low from edge 10 -> Speed 0->1 at edge 18, Changed high cycle 18-19 only; held longer -> Speed 2 at edge 26, 3 at edge 34, stays 3 at 42 with no Changed.
REQ-027 KeyUp_n low for 3 cycles then high, repeated 5 times -> Speed stays 0, Changed never asserts.
REQ-028 Speed=2, KeyUp_n and KeyDown_n low on same edge -> Speed stays 2, no Changed; then KeyDown_n released -> up repeats continue from 2 to 3.
REQ-029 Speed=0, KeyDown_n pressed and held 40 cycles -> Speed stays 0, Changed never asserts.
REQ-030 KeyUp_n low, Reset pulsed at debounce count 2, key still held -> Speed=0 after reset, single increment to 1 exactly DEBOUNCE_CYCLES+4 edges after reset deasserts.
REQ-031 REPEAT_CYCLES=0 variant, KeyUp_n held 100 cycles -> exactly one increment.
